// File: rtl/mod12_seq_checker_if.sv
// Observation/result bundle for mod12_seq_checker: the observed counter
// signals flow into the checker, tracking status and statistics flow out.
interface mod12_seq_checker_if;
    logic       clr;
    logic       valid;
    logic       load;
    logic       mode;
    logic [3:0] din;
    logic [3:0] cnt;
    logic [3:0] exp_cnt;
    logic       synced;
    logic       err;
    logic       fault;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic       range_err;

    modport master (
        output clr, valid, load, mode, din, cnt,
        input  exp_cnt, synced, err, fault, err_cnt, wrap_cnt, range_err
    );

    modport slave (
        input  clr, valid, load, mode, din, cnt,
        output exp_cnt, synced, err, fault, err_cnt, wrap_cnt, range_err
    );
endinterface

// File: rtl/mod12_seq_checker.sv
// Shadows an observed mod-12 up/down counter and reports divergence.
// Out-of-range (cnt>11) detection is built only when MOD12_SEQ_CHECKER_RANGE_CHECK_EN is defined.
module mod12_seq_checker (
    input  logic               clk,
    input  logic               rst,
    mod12_seq_checker_if.slave bus
);
    // state  | meaning
    // UNSYNC | no reference yet; the next sample only seeds exp_cnt
    // TRACK  | every sample is compared against exp_cnt
    // FAULT  | a mismatch was seen; two consecutive matches return to TRACK
    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t     state;
    logic       run;
    logic [3:0] exp_q;
    logic       synced_q;
    logic       fault_q;
    logic       err_q;
    logic [7:0] err_cnt_q;
    logic [7:0] wrap_cnt_q;
    logic       mismatch;
    logic       wrap_hit;
    logic       range_hit;
    logic       err_bump;

    function automatic logic [3:0] next_val(input logic [3:0] v, input logic ld,
                                            input logic md, input logic [3:0] d);
        if (ld)
            return d;
        else if (md)
            return (v == 4'd11) ? 4'd0 : v + 4'd1;
        else
            return (v == 4'd0) ? 4'd11 : v - 4'd1;
    endfunction

    assign mismatch = (state != UNSYNC) && (bus.cnt != exp_q);
    assign wrap_hit = (state != UNSYNC) && !mismatch && !bus.load &&
                      (bus.mode ? (bus.cnt == 4'd11) : (bus.cnt == 4'd0));
    assign err_bump = bus.valid && (mismatch || range_hit);

`ifdef MOD12_SEQ_CHECKER_RANGE_CHECK_EN
    logic range_err_q;

    assign range_hit = bus.cnt > 4'd11;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            range_err_q <= 1'b0;
        else if (bus.clr)
            range_err_q <= 1'b0;
        else
            range_err_q <= bus.valid && range_hit;
    end

    assign bus.range_err = range_err_q;
`else
    assign range_hit     = 1'b0;
    assign bus.range_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= UNSYNC;
            run        <= 1'b0;
            exp_q      <= 4'd0;
            synced_q   <= 1'b0;
            fault_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            wrap_cnt_q <= 8'd0;
        end else if (bus.clr) begin
            // clr wins over a coincident sample, which is dropped
            state      <= UNSYNC;
            run        <= 1'b0;
            exp_q      <= 4'd0;
            synced_q   <= 1'b0;
            fault_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            wrap_cnt_q <= 8'd0;
        end else begin
            err_q <= 1'b0;
            if (bus.valid) begin
                exp_q <= next_val(bus.cnt, bus.load, bus.mode, bus.din);
                if (err_bump && err_cnt_q != 8'hff)
                    err_cnt_q <= err_cnt_q + 8'd1;
                if (wrap_hit && wrap_cnt_q != 8'hff)
                    wrap_cnt_q <= wrap_cnt_q + 8'd1;
                case (state)
                    UNSYNC: begin
                        state    <= TRACK;
                        synced_q <= 1'b1;
                        fault_q  <= 1'b0;
                        run      <= 1'b0;
                    end
                    TRACK: begin
                        if (mismatch) begin
                            err_q   <= 1'b1;
                            state   <= FAULT;
                            fault_q <= 1'b1;
                            run     <= 1'b0;
                        end
                    end
                    FAULT: begin
                        if (mismatch) begin
                            err_q <= 1'b1;
                            run   <= 1'b0;
                        end else if (run) begin
                            state   <= TRACK;
                            fault_q <= 1'b0;
                            run     <= 1'b0;
                        end else begin
                            run <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= UNSYNC;
                        synced_q <= 1'b0;
                        fault_q  <= 1'b0;
                        run      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.exp_cnt  = exp_q;
    assign bus.synced   = synced_q;
    assign bus.fault    = fault_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.wrap_cnt = wrap_cnt_q;
endmodule

// File: tb/tb_mod12_seq_checker.sv
// Bench for mod12_seq_checker: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the checker.
module tb_mod12_seq_checker;
`ifdef MOD12_SEQ_CHECKER_RANGE_CHECK_EN
    localparam int RC = 1;
`else
    localparam int RC = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    mod12_seq_checker_if bus ();

    mod12_seq_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the checker's observable behaviour
    bit m_sync, m_fault, m_err, m_rerr;
    int m_run, m_exp, m_errc, m_wrapc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int nxt(input int v, input int ld, input int md, input int d);
        if (ld != 0) return d;
        if (md != 0) return (v == 11) ? 0 : (v + 1) % 16;
        return (v == 0) ? 11 : v - 1;
    endfunction

    task automatic model_reset();
        m_sync = 0; m_fault = 0; m_err = 0; m_rerr = 0;
        m_run = 0; m_exp = 0; m_errc = 0; m_wrapc = 0;
    endtask

    task automatic model_step(input int v, input int ld, input int md, input int d,
                              input int c, input int cl);
        bit miss, rng;
        m_err = 0;
        m_rerr = 0;
        if (cl != 0) begin
            model_reset();
        end else if (v != 0) begin
            rng  = (RC != 0) && (c > 11);
            miss = m_sync && (c != m_exp);
            if ((miss || rng) && m_errc < 255) m_errc++;
            if (m_sync && !miss && ld == 0 && ((md != 0 && c == 11) || (md == 0 && c == 0))
                && m_wrapc < 255)
                m_wrapc++;
            m_err  = miss;
            m_rerr = rng;
            if (!m_sync) begin
                m_sync = 1;
            end else if (miss) begin
                m_fault = 1;
                m_run   = 0;
            end else if (m_fault) begin
                m_run++;
                if (m_run == 2) begin
                    m_fault = 0;
                    m_run   = 0;
                end
            end
            m_exp = nxt(c, ld, md, d);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".exp_cnt"},   32'(bus.exp_cnt),   m_exp);
        chk({tag, ".synced"},    32'(bus.synced),    32'(m_sync));
        chk({tag, ".fault"},     32'(bus.fault),     32'(m_fault));
        chk({tag, ".err"},       32'(bus.err),       32'(m_err));
        chk({tag, ".err_cnt"},   32'(bus.err_cnt),   m_errc);
        chk({tag, ".wrap_cnt"},  32'(bus.wrap_cnt),  m_wrapc);
        chk({tag, ".range_err"}, 32'(bus.range_err), 32'(m_rerr));
    endtask

    task automatic step(input string tag, input int v, input int ld, input int md,
                        input int d, input int c, input int cl);
        @(negedge clk);
        bus.valid = v[0];
        bus.load  = ld[0];
        bus.mode  = md[0];
        bus.din   = d[3:0];
        bus.cnt   = c[3:0];
        bus.clr   = cl[0];
        @(posedge clk);
        model_step(v, ld, md, d, c, cl);
        #1;
        compare_all(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clr = 0; bus.valid = 0; bus.load = 0; bus.mode = 0; bus.din = 0; bus.cnt = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // up count with one wrap; first sample only resyncs
        for (int i = 0; i <= 11; i++) step("up", 1, 0, 1, 0, i, 0);
        step("up", 1, 0, 1, 0, 0, 0);
        chk("up.wrap_cnt_1", 32'(bus.wrap_cnt), 1);
        chk("up.synced_1",   32'(bus.synced),   1);
        chk("up.err_cnt_0",  32'(bus.err_cnt),  0);

        // down wrap, then a load
        step("clr", 0, 0, 0, 0, 0, 1);
        step("dn", 1, 0, 0, 0, 1, 0);
        step("dn", 1, 0, 0, 0, 0, 0);
        step("dn", 1, 0, 0, 0, 11, 0);
        step("dn", 1, 1, 0, 5, 10, 0);
        step("dn", 1, 0, 0, 0, 5, 0);
        chk("dn.wrap_cnt_1", 32'(bus.wrap_cnt), 1);
        chk("dn.exp_cnt_4",  32'(bus.exp_cnt),  4);
        chk("dn.err_cnt_0",  32'(bus.err_cnt),  0);

        // injected mismatch and recovery
        step("clr", 0, 0, 0, 0, 0, 1);
        step("mm", 1, 0, 1, 0, 6, 0);
        chk("mm.exp_cnt_7", 32'(bus.exp_cnt), 7);
        step("mm", 1, 0, 1, 0, 9, 0);
        chk("mm.err_pulse", 32'(bus.err),     1);
        chk("mm.err_cnt_1", 32'(bus.err_cnt), 1);
        chk("mm.fault_1",   32'(bus.fault),   1);
        step("mm", 1, 0, 1, 0, 10, 0);
        chk("mm.err_drop",  32'(bus.err),     0);
        chk("mm.fault_run", 32'(bus.fault),   1);
        step("mm", 0, 0, 1, 0, 3, 0);
        step("mm", 1, 0, 1, 0, 11, 0);
        chk("mm.fault_0",   32'(bus.fault),   0);

        // saturation then clr with coincident sample
        for (int i = 0; i < 300; i++) step("sat", 1, 0, 1, 0, (m_exp + 2) % 12, 0);
        chk("sat.err_cnt_255", 32'(bus.err_cnt), 255);
        step("satclr", 1, 0, 1, 0, 3, 1);
        chk("satclr.synced_0",  32'(bus.synced),  0);
        chk("satclr.err_cnt_0", 32'(bus.err_cnt), 0);
        chk("satclr.exp_0",     32'(bus.exp_cnt), 0);

        // out-of-range value that matches the model
        step("rng", 1, 0, 1, 0, 0, 0);
        step("rng", 1, 1, 1, 13, 1, 0);
        step("rng", 1, 0, 1, 0, 13, 0);
        chk("rng.range_err", 32'(bus.range_err), RC);
        chk("rng.err_cnt",   32'(bus.err_cnt),   RC);
        chk("rng.err_0",     32'(bus.err),       0);

        // async reset while in FAULT
        step("ar", 1, 0, 1, 0, 2, 0);
        step("ar", 1, 0, 1, 0, 8, 0);
        chk("ar.fault_1", 32'(bus.fault), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        @(negedge clk);
        #2 rst = 1'b1;
        step("ar_post", 1, 0, 1, 0, 9, 0);
        step("ar_post", 1, 0, 1, 0, 10, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int v, ld, md, d, c, cl;
            v  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            cl = ($urandom_range(0, 59) == 0) ? 1 : 0;
            ld = ($urandom_range(0, 7) == 0) ? 1 : 0;
            md = int'($urandom_range(0, 1));
            d  = int'($urandom_range(0, 15));
            c  = ($urandom_range(0, 3) != 0) ? m_exp : int'($urandom_range(0, 15));
            step("rand", v, ld, md, d, c, cl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
